// File: rtl/clm_mul_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : clm_mul_arbiter_if
// Description : Bundle of requester, response, RNG and multiplier signals
//               shared between clm_mul_arbiter and its environment.
//               slave  = arbiter view, master = environment view.
// Revision    : 1.0 - initial release
// ============================================================================
interface clm_mul_arbiter_if #(
  parameter int D    = 2,
  parameter int NREQ = 4
);
  localparam int W = 8 + D;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][W-1:0] req_p1;
  logic [NREQ-1:0][W-1:0] req_p2;
  logic [NREQ-1:0]        resp_valid;
  logic [NREQ-1:0]        resp_ready;
  logic [W-1:0]           resp_data;
  logic                   rnd_valid;
  logic                   rnd_ready;
  logic                   mul_drdy_i;
  logic [W-1:0]           mul_p1;
  logic [W-1:0]           mul_p2;
  logic                   mul_drdy_o;
  logic [W-1:0]           mul_out;

  modport slave (
    input  req_valid, req_p1, req_p2, resp_ready, rnd_valid, mul_drdy_o, mul_out,
    output req_ready, resp_valid, resp_data, rnd_ready, mul_drdy_i, mul_p1, mul_p2
  );

  modport master (
    output req_valid, req_p1, req_p2, resp_ready, rnd_valid, mul_drdy_o, mul_out,
    input  req_ready, resp_valid, resp_data, rnd_ready, mul_drdy_i, mul_p1, mul_p2
  );
endinterface
`default_nettype wire

// File: rtl/clm_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : clm_mul_arbiter
// Description : Round-robin arbiter/sequencer sharing one serial masked CLM
//               multiplier among NREQ requesters. One operation in flight:
//               accept -> start multiplier -> wait done -> return result.
//               Optional macro CLM_ARB_TIMEOUT_EN adds a WAIT watchdog and
//               the sticky timeout_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module clm_mul_arbiter #(
  parameter int D    = 2,
  parameter int NREQ = 4,
  parameter int GW   = $clog2(NREQ)
) (
  input  wire logic        clk,
  input  wire logic        rst,
  clm_mul_arbiter_if.slave bus,
  output logic             busy,
  output logic [GW-1:0]    grant_idx
`ifdef CLM_ARB_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);
  localparam int W  = 8 + D;
  localparam int IW = GW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      state_q,  state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   grant_q,  grant_d;
  logic [W-1:0]    p1_q,     p1_d;
  logic [W-1:0]    p2_q,     p2_d;
  logic [W-1:0]    res_q,    res_d;

  logic [NREQ-1:0] req_ready_c;
  logic [NREQ-1:0] resp_valid_c;
  logic            rnd_ready_c;
  logic            start_c;

  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  logic [IW-1:0]   scan_idx;

`ifdef CLM_ARB_TIMEOUT_EN
  // Watchdog: WAIT gives up after this many cycles without a done level.
  localparam int TO_CYC = 16 + D;
  localparam int CW     = $clog2(TO_CYC + 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q,  timeout_d;
`endif

  // Round-robin search: first pending requester starting at rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + IW'(i);
      if (scan_idx >= IW'(NREQ)) scan_idx = scan_idx - IW'(NREQ);
      if (!pick_found && bus.req_valid[scan_idx[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[GW-1:0];
      end
    end
  end

  // Sequencer next-state and strobe generation; strobes are silenced under reset.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    res_d        = res_q;
    req_ready_c  = '0;
    resp_valid_c = '0;
    rnd_ready_c  = 1'b0;
    start_c      = 1'b0;
`ifdef CLM_ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
`endif
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          // A grant also needs a fresh random vector ready for the multiplier.
          if (pick_found && bus.rnd_valid) begin
            req_ready_c[pick_idx] = 1'b1;
            p1_d                  = bus.req_p1[pick_idx];
            p2_d                  = bus.req_p2[pick_idx];
            grant_d               = pick_idx;
            state_d               = S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef CLM_ARB_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
          // Start and RNG consume are the same event.
          if (bus.rnd_valid) begin
            start_c     = 1'b1;
            rnd_ready_c = 1'b1;
            state_d     = S_WAIT;
          end
        end
        S_WAIT: begin
          // The multiplier clears its done level on the start edge, so any
          // level seen here belongs to the current operation.
          if (bus.mul_drdy_o) begin
            res_d   = bus.mul_out;
            state_d = S_RESP;
          end
`ifdef CLM_ARB_TIMEOUT_EN
          else if (wait_cnt_q == CW'(TO_CYC - 1)) begin
            res_d     = '0;
            timeout_d = 1'b1;
            state_d   = S_RESP;
          end
          wait_cnt_d = wait_cnt_q + CW'(1);
`endif
        end
        S_RESP: begin
          resp_valid_c[grant_q] = 1'b1;
          if (bus.resp_ready[grant_q]) begin
            rr_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      res_q      <= '0;
`ifdef CLM_ARB_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      res_q      <= res_d;
`ifdef CLM_ARB_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_data  = res_q;
  assign bus.rnd_ready  = rnd_ready_c;
  assign bus.mul_drdy_i = start_c;
  assign bus.mul_p1     = p1_q;
  assign bus.mul_p2     = p2_q;
  assign busy           = (state_q != S_IDLE);
  assign grant_idx      = grant_q;
`ifdef CLM_ARB_TIMEOUT_EN
  assign timeout_err    = timeout_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clm_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clm_mul_arbiter
// Description : Self-checking bench for clm_mul_arbiter (D=2, NREQ=4) with a
//               behavioural multiplier stub, a vector table, hand-written
//               corner sequences and a randomized run against a
//               transaction-level model. Honours CLM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clm_mul_arbiter;
  localparam int D        = 2;
  localparam int NREQ     = 4;
  localparam int GW       = 2;
  localparam int W        = 8 + D;
  localparam int MUL_LAT  = 9 + D;   // cycles spent in WAIT
  localparam int LAT_RESP = 11 + D;  // req_ready -> resp_valid

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic [GW-1:0] grant_idx;
`ifdef CLM_ARB_TIMEOUT_EN
  logic timeout_err;
`endif
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  clm_mul_arbiter_if #(.D(D), .NREQ(NREQ)) bus ();

  clm_mul_arbiter #(.D(D), .NREQ(NREQ), .GW(GW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .grant_idx (grant_idx)
`ifdef CLM_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in product: carry-less multiply folded back to W bits.
  function automatic logic [W-1:0] gmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++) if (b[i]) p = p ^ ({{W{1'b0}}, a} << i);
    return p[W-1:0] ^ p[2*W-1:W];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] rv, input int rr);
    for (int i = 0; i < NREQ; i++) if (rv[(rr + i) % NREQ]) return (rr + i) % NREQ;
    return -1;
  endfunction

  // Multiplier stub: done level rises MUL_LAT cycles after start, cleared by start.
  logic stuck = 1'b0;
  logic mdone;
  int   mcnt;
  logic [W-1:0] junk;
  always @(posedge clk) begin
    junk <= W'($urandom);
    if (rst) begin
      mcnt  <= 0;
      mdone <= 1'b0;
    end else if (bus.mul_drdy_i) begin
      mcnt  <= MUL_LAT - 1;
      mdone <= 1'b0;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      mcnt  <= 0;
      mdone <= !stuck;
    end
  end
  assign bus.mul_drdy_o = mdone;
  assign bus.mul_out    = mdone ? gmul(bus.mul_p1, bus.mul_p2) : junk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 100) begin @(negedge clk); k++; end
    chk({nm, " drain"}, 64'(busy), 64'(0));
  endtask

  // One operation with rnd_valid high and resp_ready high.
  task automatic do_op(input logic [NREQ-1:0] rv, input int g, input logic [W-1:0] p1,
                       input logic [W-1:0] p2, input int lat, input logic [W-1:0] exp_d,
                       input string nm);
    int t0;
    int k;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_p1[i] = (i == g) ? p1 : (~p1 ^ W'(i));
      bus.req_p2[i] = (i == g) ? p2 : (p2 ^ W'(i + 1));
    end
    bus.req_valid  = rv;
    bus.rnd_valid  = 1'b1;
    bus.resp_ready = '1;
    @(negedge clk);
    k = 0;
    while (bus.req_ready == '0 && k < 40) begin @(negedge clk); k++; end
    chk({nm, " grant"}, 64'(bus.req_ready), 64'(onehot(g)));
    t0 = cyc;
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk({nm, " start"}, 64'(bus.mul_drdy_i), 64'(1));
    k = 0;
    while (bus.resp_valid == '0 && k < 60) begin @(negedge clk); k++; end
    chk({nm, " latency"}, 64'(cyc - t0), 64'(lat));
    chk({nm, " resp_valid"}, 64'(bus.resp_valid), 64'(onehot(g)));
    chk({nm, " resp_data"}, 64'(bus.resp_data), 64'(exp_d));
    chk({nm, " grant_idx"}, 64'(grant_idx), 64'(g));
  endtask

  typedef struct {
    logic [NREQ-1:0] rv;
    int              g;
    logic [W-1:0]    p1;
    logic [W-1:0]    p2;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int k;
    int prev;
    int stall_d;
    logic [W-1:0] d0;
    // model state for the randomized run
    int m_rr;
    int m_g;
    int age;
    int pk;
    logic m_busy;
    logic m_started;
    logic [W-1:0] m_d;
    logic [NREQ-1:0] exp_rdy;
    logic exp_start;

    // Grant order derived by hand from rr_ptr=0 after reset.
    tbl[0] = '{4'b0100, 2, 10'h2A5, 10'h13C};
    tbl[1] = '{4'b0011, 0, 10'h1F0, 10'h00F};
    tbl[2] = '{4'b1001, 3, 10'h3FF, 10'h3FF};
    tbl[3] = '{4'b1111, 0, 10'h001, 10'h2AA};
    tbl[4] = '{4'b1111, 1, 10'h155, 10'h0C3};
    tbl[5] = '{4'b0001, 0, 10'h000, 10'h123};
    tbl[6] = '{4'b1100, 2, 10'h2B7, 10'h1A1};
    tbl[7] = '{4'b0110, 1, 10'h0E4, 10'h377};

    bus.req_valid  = '0;
    bus.req_p1     = '0;
    bus.req_p2     = '0;
    bus.resp_ready = '0;
    bus.rnd_valid  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset grant_idx", 64'(grant_idx), 64'(0));
    chk("reset strobes", 64'({bus.req_ready, bus.resp_valid, bus.rnd_ready, bus.mul_drdy_i}), 64'(0));
    chk("reset regs", 64'({bus.mul_p1, bus.mul_p2, bus.resp_data}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Vector table
    for (int v = 0; v < 8; v++)
      do_op(tbl[v].rv, tbl[v].g, tbl[v].p1, tbl[v].p2, LAT_RESP,
            gmul(tbl[v].p1, tbl[v].p2), $sformatf("vec%0d", v));

    // All four requesting continuously: order 0,1,2,3,0 spaced 14 cycles
    wait_idle("vecs");
    do_reset();
    bus.req_valid  = '1;
    bus.rnd_valid  = 1'b1;
    bus.resp_ready = '1;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      k = 0;
      while (bus.req_ready == '0 && k < 40) begin @(negedge clk); k++; end
      chk($sformatf("rr grant%0d", n), 64'(bus.req_ready), 64'(onehot(n % NREQ)));
      if (n > 0) chk($sformatf("rr spacing%0d", n), 64'(cyc - prev), 64'(LAT_RESP + 1));
      prev = cyc;
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle("rr");

    // No random vector: nothing accepted; acceptance same cycle rnd_valid rises
    @(posedge clk); #1;
    bus.rnd_valid = 1'b0;
    bus.req_valid = 4'b0001;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("norng quiet", 64'({bus.req_ready, bus.mul_drdy_i, busy}), 64'(0));
      @(posedge clk); #1;
    end
    bus.rnd_valid = 1'b1;
    @(negedge clk);
    chk("norng accept", 64'(bus.req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle("norng");

    // Response stall on requester 1 with other requests pending
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_p1[i] = W'(10'h0A7 + i);
      bus.req_p2[i] = W'(10'h311 - i);
    end
    bus.req_valid  = 4'b0010;
    bus.resp_ready = 4'b1101;
    @(negedge clk);
    k = 0;
    while (bus.req_ready == '0 && k < 40) begin @(negedge clk); k++; end
    chk("stall grant", 64'(bus.req_ready), 64'(4'b0010));
    @(posedge clk); #1;
    bus.req_valid = 4'b1101;
    @(negedge clk);
    k = 0;
    while (bus.resp_valid == '0 && k < 60) begin @(negedge clk); k++; end
    d0 = bus.resp_data;
    chk("stall data", 64'(d0), 64'(gmul(W'(10'h0A8), W'(10'h310))));
    stall_d = 0;
    for (int s = 0; s < 10; s++) begin
      if (s > 0) @(negedge clk);
      if (bus.resp_valid !== 4'b0010 || bus.resp_data !== d0 || bus.req_ready !== '0) stall_d++;
    end
    chk("stall stable", 64'(stall_d), 64'(0));
    @(posedge clk); #1;
    bus.resp_ready = '1;
    @(negedge clk);
    chk("stall handshake", 64'(bus.resp_valid), 64'(4'b0010));
    @(negedge clk);
    chk("stall idle", 64'(busy), 64'(0));
    chk("stall next grant", 64'(bus.req_ready), 64'(4'b0100));
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_idle("stall");

    // Reset during WAIT aborts the operation
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("abort grant", 64'(bus.req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort outputs", 64'({busy, grant_idx, bus.req_ready, bus.resp_valid, bus.rnd_ready, bus.mul_drdy_i}), 64'(0));
    chk("abort regs", 64'({bus.mul_p1, bus.resp_data}), 64'(0));
    k = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.resp_valid != '0 || busy) k++;
    end
    chk("abort no resp", 64'(k), 64'(0));
    do_op(4'b1000, 3, 10'h19B, 10'h2E6, LAT_RESP, gmul(10'h19B, 10'h2E6), "after abort");
    wait_idle("abort");

`ifdef CLM_ARB_TIMEOUT_EN
    // Multiplier never finishes: timeout after 16+D WAIT cycles, zero result
    stuck = 1'b1;
    chk("timeout pre", 64'(timeout_err), 64'(0));
    do_op(4'b0100, 2, 10'h3C3, 10'h0F1, 2 + 16 + D, '0, "timeout");
    chk("timeout err", 64'(timeout_err), 64'(1));
    wait_idle("timeout");
    chk("timeout sticky", 64'(timeout_err), 64'(1));
    stuck = 1'b0;
`endif

    // Randomized run against a transaction-level model
    do_reset();
    m_rr      = 0;
    m_busy    = 1'b0;
    m_started = 1'b0;
    m_g       = 0;
    m_d       = '0;
    age       = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.req_valid  = NREQ'($urandom);
      bus.rnd_valid  = ($urandom_range(0, 3) != 0);
      bus.resp_ready = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        bus.req_p1[i] = W'($urandom);
        bus.req_p2[i] = W'($urandom);
      end
      @(negedge clk);
      if (!m_busy) begin
        pk = rr_pick(bus.req_valid, m_rr);
        exp_rdy = (bus.rnd_valid && pk >= 0) ? onehot(pk) : '0;
        chk("rand grant", 64'(bus.req_ready), 64'(exp_rdy));
        chk("rand idle", 64'({bus.resp_valid, busy, bus.mul_drdy_i, bus.rnd_ready}), 64'(0));
        if (exp_rdy != '0) begin
          m_busy    = 1'b1;
          m_started = 1'b0;
          m_g       = pk;
          m_d       = gmul(bus.req_p1[pk], bus.req_p2[pk]);
          age       = 0;
        end
      end else begin
        exp_start = !m_started && bus.rnd_valid;
        chk("rand start", 64'({bus.mul_drdy_i, bus.rnd_ready}), 64'({exp_start, exp_start}));
        chk("rand busy", 64'({busy, bus.req_ready}), 64'({1'b1, {NREQ{1'b0}}}));
        if (exp_start) m_started = 1'b1;
        if (bus.resp_valid != '0) begin
          chk("rand resp_valid", 64'(bus.resp_valid), 64'(onehot(m_g)));
          chk("rand resp_data", 64'(bus.resp_data), 64'(m_d));
          chk("rand grant_idx", 64'(grant_idx), 64'(m_g));
          if (bus.resp_ready[m_g]) begin
            m_busy = 1'b0;
            m_rr   = (m_g + 1) % NREQ;
          end
        end
        age++;
        if (age > 200) begin
          chk("rand op timeout", 64'(age), 64'(200));
          break;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
